// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported synchronous memory between data, fetch and debug
// requesters. Fixed priority data > fetch > debug, with fetch aging against data.
module unified_mem_arbiter #(
  parameter int XLEN       = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [3:0]      d_be_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  input  logic            f_req_i,
  input  logic [XLEN-1:0] f_addr_i,
  output logic            f_gnt_o,
  output logic            f_rvalid_o,
  input  logic            dbg_req_i,
  input  logic [XLEN-1:0] dbg_addr_i,
  output logic            dbg_gnt_o,
  output logic            dbg_rvalid_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            busy_o
);

  // Handshake: a *_req_i level is granted by a one-cycle *_gnt_o pulse while IDLE;
  // reads answer later with a one-cycle *_rvalid_o, rdata_o valid in that cycle.

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {ID_D, ID_F, ID_DBG} id_t;

  state_t          state_q, state_d;
  id_t             id_q, id_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            we_q, we_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            fetch_aged;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    d_gnt_o    = 1'b0;
    f_gnt_o    = 1'b0;
    dbg_gnt_o  = 1'b0;
    fetch_aged = f_req_i && (starve_q == SW'(STARVE_MAX));
    case (state_q)
      IDLE: begin
        // Grants are suppressed while reset is held so no pulse escapes it.
        if (!rst_i) begin
          if (d_req_i && !fetch_aged) begin
            d_gnt_o = 1'b1;
            id_d    = ID_D;
            we_d    = d_we_i;
            be_d    = d_we_i ? d_be_i : 4'hF;
            addr_d  = d_addr_i;
            wdata_d = d_wdata_i;
            state_d = ISSUE;
            if (f_req_i && (starve_q != SW'(STARVE_MAX))) starve_d = starve_q + SW'(1);
          end else if (f_req_i) begin
            f_gnt_o  = 1'b1;
            id_d     = ID_F;
            we_d     = 1'b0;
            be_d     = 4'hF;
            addr_d   = f_addr_i;
            wdata_d  = '0;
            state_d  = ISSUE;
            starve_d = '0;
          end else if (dbg_req_i) begin
            dbg_gnt_o = 1'b1;
            id_d      = ID_DBG;
            we_d      = 1'b0;
            be_d      = 4'hF;
            addr_d    = dbg_addr_i;
            wdata_d   = '0;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = we_q ? IDLE : WAIT;
        cnt_d   = LW'(MEM_LAT - 1);
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata_i;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - LW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      id_q     <= ID_D;
      cnt_q    <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mem_req_o    = (state_q == ISSUE);
  assign mem_we_o     = mem_req_o && we_q;
  assign mem_be_o     = be_q;
  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign rdata_o      = rdata_q;
  assign busy_o       = (state_q != IDLE);
  assign d_rvalid_o   = (state_q == RESP) && (id_q == ID_D);
  assign f_rvalid_o   = (state_q == RESP) && (id_q == ID_F);
  assign dbg_rvalid_o = (state_q == RESP) && (id_q == ID_DBG);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: cycle-accurate transaction model checked every
// cycle, plus directed scenarios with hand-computed timing and data.
module tb_unified_mem_arbiter;
  localparam int XLEN       = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic            clk, rst_i;
  logic            d_req_i, d_we_i;
  logic [3:0]      d_be_i;
  logic [XLEN-1:0] d_addr_i, d_wdata_i;
  logic            d_gnt_o, d_rvalid_o;
  logic            f_req_i;
  logic [XLEN-1:0] f_addr_i;
  logic            f_gnt_o, f_rvalid_o;
  logic            dbg_req_i;
  logic [XLEN-1:0] dbg_addr_i;
  logic            dbg_gnt_o, dbg_rvalid_o;
  logic [XLEN-1:0] rdata_o;
  logic            mem_req_o, mem_we_o;
  logic [3:0]      mem_be_o;
  logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic            busy_o;

  unified_mem_arbiter #(.XLEN(XLEN), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .f_req_i(f_req_i), .f_addr_i(f_addr_i), .f_gnt_o(f_gnt_o), .f_rvalid_o(f_rvalid_o),
    .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_gnt_o(dbg_gnt_o),
    .dbg_rvalid_o(dbg_rvalid_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h40:  mem_word = 32'h0050_0093;
      32'h200: mem_word = 32'h1234_5678;
      default: mem_word = a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // ---------------- memory: data valid only MEM_LAT cycles after the strobe ----------------
  int rd_at = -1;
  logic [31:0] rd_word = '0;
  initial begin
    mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (mem_req_o && !mem_we_o) begin
        rd_at   = cyc + MEM_LAT;
        rd_word = mem_word(mem_addr_o);
      end
      mem_rdata_i = (cyc == rd_at) ? rd_word : (32'hBAD0_0000 ^ 32'(cyc));
    end
  end

  // ---------------- requester drivers ----------------
  int d_left = 0, f_left = 0, b_left = 0;
  logic g_d = 0, g_f = 0, g_b = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (g_d) begin d_left--; d_addr_i += 32'd4; d_wdata_i += 32'd1; end
    if (g_f) begin f_left--; f_addr_i += 32'd4; end
    if (g_b) begin b_left--; dbg_addr_i += 32'd4; end
    d_req_i   = !rst_i && (d_left > 0);
    f_req_i   = !rst_i && (f_left > 0);
    dbg_req_i = !rst_i && (b_left > 0);
  end

  // ---------------- monitor records ----------------
  logic [7:0]  log_q[$];
  int          d_gnt_cyc = -1, f_gnt_cyc = -1, b_gnt_cyc = -1;
  int          req_cyc = -1, rv_cyc = -1;
  logic [31:0] req_addr, req_wdata, rv_data;
  logic [3:0]  req_be;
  logic        req_we;
  int          rv_d = 0, rv_f = 0, rv_b = 0;

  // ---------------- transaction model + per-cycle compare ----------------
  int          m_k = 0, m_len = 0, m_owner = 0, m_starve = 0, w;
  logic        m_we = 0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [2:0]  e_gnt, e_rv;
  logic        e_req;

  initial forever begin
    @(negedge clk);
    g_d = d_gnt_o; g_f = f_gnt_o; g_b = dbg_gnt_o;
    if (d_gnt_o)   begin log_q.push_back("D"); d_gnt_cyc = cyc; end
    if (f_gnt_o)   begin log_q.push_back("F"); f_gnt_cyc = cyc; end
    if (dbg_gnt_o) begin log_q.push_back("B"); b_gnt_cyc = cyc; end
    if (mem_req_o) begin
      req_cyc = cyc; req_addr = mem_addr_o; req_we = mem_we_o;
      req_be = mem_be_o; req_wdata = mem_wdata_o;
    end
    if (d_rvalid_o || f_rvalid_o || dbg_rvalid_o) begin rv_cyc = cyc; rv_data = rdata_o; end
    rv_d += int'(d_rvalid_o); rv_f += int'(f_rvalid_o); rv_b += int'(dbg_rvalid_o);

    if (rst_i) begin
      check("rst_gnt", {d_gnt_o, f_gnt_o, dbg_gnt_o}, 3'b000);
      check("rst_rvalid", {d_rvalid_o, f_rvalid_o, dbg_rvalid_o}, 3'b000);
      check("rst_mem", {mem_req_o, mem_we_o, mem_be_o, busy_o}, 7'd0);
      check("rst_data", {mem_addr_o, mem_wdata_o}, 64'd0);
      check("rst_rdata", rdata_o, 32'd0);
      m_k = 0; m_starve = 0; m_we = 0; m_be = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      e_gnt = 3'b000; e_rv = 3'b000; e_req = 1'b0; w = -1;
      if (m_k == 0) begin
        if (d_req_i && !(f_req_i && m_starve == STARVE_MAX)) w = 0;
        else if (f_req_i) w = 1;
        else if (dbg_req_i) w = 2;
        if (w == 0) e_gnt = 3'b100;
        if (w == 1) e_gnt = 3'b010;
        if (w == 2) e_gnt = 3'b001;
      end else begin
        e_req = (m_k == 1);
        if (!m_we && m_k == MEM_LAT + 2) begin
          if (m_owner == 0) e_rv = 3'b100;
          if (m_owner == 1) e_rv = 3'b010;
          if (m_owner == 2) e_rv = 3'b001;
        end
      end
      check("gnt", {d_gnt_o, f_gnt_o, dbg_gnt_o}, e_gnt);
      check("rvalid", {d_rvalid_o, f_rvalid_o, dbg_rvalid_o}, e_rv);
      check("mem_req", mem_req_o, e_req);
      check("busy", busy_o, m_k != 0);
      check("rdata", rdata_o, m_rdata);
      if (e_req) begin
        check("mem_addr", mem_addr_o, m_addr);
        check("mem_we", mem_we_o, m_we);
        check("mem_be", mem_be_o, m_be);
        if (m_we) check("mem_wdata", mem_wdata_o, m_wdata);
      end
      if (w >= 0) begin
        m_owner = w; m_k = 1;
        if (w == 0) begin
          m_we = d_we_i; m_be = d_we_i ? d_be_i : 4'hF; m_addr = d_addr_i; m_wdata = d_wdata_i;
          if (f_req_i && m_starve < STARVE_MAX) m_starve++;
        end else begin
          m_we = 1'b0; m_be = 4'hF; m_addr = (w == 1) ? f_addr_i : dbg_addr_i;
          if (w == 1) m_starve = 0;
        end
        m_len = m_we ? 1 : MEM_LAT + 2;
      end else if (m_k != 0) begin
        if (!m_we && m_k == MEM_LAT + 1) m_rdata = mem_word(m_addr);
        m_k = (m_k == m_len) ? 0 : m_k + 1;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_done(input int budget, output int done_at);
    done_at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      #2;
      if (d_left == 0 && f_left == 0 && b_left == 0 && !busy_o &&
          !d_req_i && !f_req_i && !dbg_req_i) begin
        done_at = cyc;
        break;
      end
    end
    if (done_at < 0) begin
      tests++; fails++;
      $display("FAIL timeout: got no idle within %0d cycles, required idle", budget);
    end
  endtask

  int done, base_d, base_f, base_b, rel;
  logic [63:0] pat;

  initial begin
    rst_i = 1'b1;
    d_req_i = 0; d_we_i = 0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
    f_req_i = 0; f_addr_i = '0; dbg_req_i = 0; dbg_addr_i = '0;
    repeat (3) @(negedge clk);
    #2;
    check("reset_busy", busy_o, 1'b0);
    check("reset_rdata", rdata_o, 32'd0);
    rst_i = 1'b0;

    // single fetch read
    f_addr_i = 32'h40; f_left = 1;
    wait_done(50, done);
    check("fetch_req_lat", req_cyc - f_gnt_cyc, 1);
    check("fetch_addr", req_addr, 32'h40);
    check("fetch_we", req_we, 1'b0);
    check("fetch_rv_lat", rv_cyc - f_gnt_cyc, 4);
    check("fetch_rdata", rv_data, 32'h0050_0093);
    check("fetch_idle_lat", done - f_gnt_cyc, 5);

    // data write
    base_d = rv_d;
    d_we_i = 1; d_be_i = 4'b0011; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF; d_left = 1;
    wait_done(50, done);
    check("wr_req_lat", req_cyc - d_gnt_cyc, 1);
    check("wr_mem", {req_we, req_be}, 5'b1_0011);
    check("wr_addr_data", {req_addr, req_wdata}, {32'h100, 32'hDEAD_BEEF});
    check("wr_no_rvalid", rv_d - base_d, 0);
    check("wr_idle_lat", done - d_gnt_cyc, 2);

    // debug read while idle
    base_d = rv_d; base_f = rv_f;
    dbg_addr_i = 32'h200; b_left = 1;
    wait_done(50, done);
    check("dbg_rv_lat", rv_cyc - b_gnt_cyc, 4);
    check("dbg_rdata", rv_data, 32'h1234_5678);
    check("dbg_no_other_rv", {32'(rv_d - base_d), 32'(rv_f - base_f)}, 64'd0);

    // all three together
    log_q.delete();
    base_d = rv_d; base_f = rv_f; base_b = rv_b;
    d_we_i = 0; d_addr_i = 32'h300; f_addr_i = 32'h44; dbg_addr_i = 32'h204;
    d_left = 1; f_left = 1; b_left = 1;
    wait_done(100, done);
    pat = '0;
    foreach (log_q[i]) pat = {pat[55:0], log_q[i]};
    check("all3_order", pat, 64'("DFB"));
    check("all3_rv", {rv_d - base_d, rv_f - base_f, rv_b - base_b}, {32'd1, 32'd1, 32'd1});
    check("all3_dbg_last", b_gnt_cyc > f_gnt_cyc && f_gnt_cyc > d_gnt_cyc, 1'b1);

    // aging: data writes back-to-back against a waiting fetch
    log_q.delete();
    d_we_i = 1; d_be_i = 4'hF; d_addr_i = 32'h400; f_addr_i = 32'h80;
    d_left = 10; f_left = 2;
    wait_done(400, done);
    pat = '0;
    for (int i = 0; i < 8 && i < log_q.size(); i++) pat = {pat[55:0], log_q[i]};
    check("aging_pattern", pat, 64'("DDDFDDDF"));
    check("aging_count", log_q.size(), 12);

    // reset during the WAIT of a fetch read
    base_f = rv_f;
    f_addr_i = 32'h48; f_left = 1;
    for (int n = 0; n < 20 && !f_gnt_o; n++) begin
      @(negedge clk);
      #2;
    end
    check("rst_fetch_granted", f_gnt_o, 1'b1);
    repeat (2) @(negedge clk);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_now_busy", {busy_o, mem_req_o, f_rvalid_o}, 3'b000);
    check("rst_now_rdata", rdata_o, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    rst_i = 1'b0;
    rel = cyc;
    d_we_i = 1; d_addr_i = 32'h500; d_left = 1;
    wait_done(50, done);
    check("rst_no_frv", rv_f - base_f, 0);
    check("rst_then_dgnt", d_gnt_cyc - rel, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end
endmodule
